// File: rtl/chacha_block_core.sv
`default_nettype none
// ============================================================================
// Module      : chacha_block_core
// Description : ChaCha keystream block generator. Stores key, block counter
//               and nonce, runs ROUNDS rounds (one round per cycle), adds
//               the initial state and streams 16 words over valid/ready.
//               The stored counter advances after each completed block.
//               Optional feature macro: CHACHA_XOR_EN (adds In_data port,
//               Out_data becomes keystream XOR In_data).
// Revision    : 1.0 - initial release
// ============================================================================
module chacha_block_core #(
    parameter int ROUNDS   = 20,
    parameter int num_bits = 32
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Load,
    input  logic [3:0]          Load_addr,
    input  logic [num_bits-1:0] Load_data,
    input  logic                Start,
    output logic                Busy,
    output logic                Out_valid,
    input  logic                Out_ready,
`ifdef CHACHA_XOR_EN
    input  logic [num_bits-1:0] In_data,
`endif
    output logic [num_bits-1:0] Out_data,
    output logic [3:0]          Out_index,
    output logic                Out_last
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_ROUND = 3'd2,
        S_ADD   = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    localparam logic [31:0] c_sigma0     = 32'h61707865;
    localparam logic [31:0] c_sigma1     = 32'h3320646e;
    localparam logic [31:0] c_sigma2     = 32'h79622d32;
    localparam logic [31:0] c_sigma3     = 32'h6b206574;
    localparam logic [4:0]  c_last_round = 5'(ROUNDS - 1);

    state_t      r_fsm;
    logic [31:0] r_key   [8];
    logic [31:0] r_counter;
    logic [31:0] r_nonce [3];
    logic [31:0] r_work  [16];
    logic [31:0] r_init  [16];
    logic [4:0]  r_round;
    logic [31:0] r_out_word;
    logic [3:0]  r_idx;
    logic        r_busy;
    logic        r_valid;
    logic        r_last;

    logic [31:0] w_init  [16];
    logic [31:0] w_round [16];
    logic [31:0] w_sum   [16];

    function automatic logic [127:0] quarter_round(
        input logic [31:0] a_in,
        input logic [31:0] b_in,
        input logic [31:0] c_in,
        input logic [31:0] d_in
    );
        logic [31:0] a, b, c, d;
        a = a_in; b = b_in; c = c_in; d = d_in;
        a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
        c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
        a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
        c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
        return {a, b, c, d};
    endfunction

    // Block input state: constants, key, counter, nonce
    always_comb begin
        w_init[0] = c_sigma0;
        w_init[1] = c_sigma1;
        w_init[2] = c_sigma2;
        w_init[3] = c_sigma3;
        for (int i = 0; i < 8; i++) w_init[4 + i] = r_key[i];
        w_init[12] = r_counter;
        for (int i = 0; i < 3; i++) w_init[13 + i] = r_nonce[i];
    end

    // One full round: column round on even round index, diagonal on odd
    always_comb begin
        w_round = r_work;
        for (int i = 0; i < 4; i++) begin
            if (!r_round[0]) begin
                {w_round[i], w_round[i + 4], w_round[i + 8], w_round[i + 12]} =
                    quarter_round(r_work[i], r_work[i + 4], r_work[i + 8], r_work[i + 12]);
            end else begin
                {w_round[i], w_round[4 + ((i + 1) % 4)], w_round[8 + ((i + 2) % 4)],
                 w_round[12 + ((i + 3) % 4)]} =
                    quarter_round(r_work[i], r_work[4 + ((i + 1) % 4)],
                                  r_work[8 + ((i + 2) % 4)], r_work[12 + ((i + 3) % 4)]);
            end
        end
    end

    // Feed-forward addition of the initial state
    always_comb begin
        for (int i = 0; i < 16; i++) w_sum[i] = r_work[i] + r_init[i];
    end

    // Control FSM, key/counter/nonce storage and registered output stage
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_fsm      <= S_IDLE;
            for (int i = 0; i < 8; i++)  r_key[i]   <= '0;
            for (int i = 0; i < 3; i++)  r_nonce[i] <= '0;
            for (int i = 0; i < 16; i++) r_work[i]  <= '0;
            for (int i = 0; i < 16; i++) r_init[i]  <= '0;
            r_counter  <= '0;
            r_round    <= '0;
            r_out_word <= '0;
            r_idx      <= '0;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_last     <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    // Load is applied in the same edge as Start, so INIT sees it
                    if (Load) begin
                        if (!Load_addr[3]) begin
                            r_key[Load_addr[2:0]] <= Load_data;
                        end else begin
                            case (Load_addr[2:0])
                                3'd0:    r_counter  <= Load_data;
                                3'd1:    r_nonce[0] <= Load_data;
                                3'd2:    r_nonce[1] <= Load_data;
                                3'd3:    r_nonce[2] <= Load_data;
                                default: ;
                            endcase
                        end
                    end
                    if (Start) begin
                        r_busy <= 1'b1;
                        r_fsm  <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_work  <= w_init;
                    r_init  <= w_init;
                    r_round <= '0;
                    r_fsm   <= S_ROUND;
                end
                S_ROUND: begin
                    r_work  <= w_round;
                    r_round <= r_round + 5'd1;
                    if (r_round == c_last_round) r_fsm <= S_ADD;
                end
                S_ADD: begin
                    r_work     <= w_sum;
                    r_out_word <= w_sum[0];
                    r_idx      <= '0;
                    r_last     <= 1'b0;
                    r_valid    <= 1'b1;
                    r_fsm      <= S_OUT;
                end
                S_OUT: begin
                    if (Out_ready) begin
                        if (r_idx == 4'd15) begin
                            r_counter  <= r_counter + 32'd1;
                            r_valid    <= 1'b0;
                            r_last     <= 1'b0;
                            r_busy     <= 1'b0;
                            r_out_word <= '0;
                            r_idx      <= '0;
                            r_fsm      <= S_IDLE;
                        end else begin
                            r_out_word <= r_work[r_idx + 4'd1];
                            r_idx      <= r_idx + 4'd1;
                            r_last     <= (r_idx == 4'd14);
                        end
                    end
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign Busy      = r_busy;
    assign Out_valid = r_valid;
    assign Out_index = r_idx;
    assign Out_last  = r_last;
`ifdef CHACHA_XOR_EN
    assign Out_data  = r_out_word ^ In_data;
`else
    assign Out_data  = r_out_word;
`endif

endmodule
`default_nettype wire

// File: tb/tb_chacha_block_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_chacha_block_core
// Description : Self-checking bench for chacha_block_core against a
//               behavioural ChaCha block model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_chacha_block_core;

    localparam int ROUNDS = 20;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Load;
    logic [3:0]  Load_addr;
    logic [31:0] Load_data;
    logic        Start;
    logic        Busy;
    logic        Out_valid;
    logic        Out_ready;
    logic [31:0] Out_data;
    logic [3:0]  Out_index;
    logic        Out_last;
`ifdef CHACHA_XOR_EN
    logic [31:0] In_data;
`endif

    chacha_block_core #(.ROUNDS(ROUNDS), .num_bits(32)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Load      (Load),
        .Load_addr (Load_addr),
        .Load_data (Load_data),
        .Start     (Start),
        .Busy      (Busy),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
`ifdef CHACHA_XOR_EN
        .In_data   (In_data),
`endif
        .Out_data  (Out_data),
        .Out_index (Out_index),
        .Out_last  (Out_last)
    );

    always #5 Clk = ~Clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_key   [8];
    logic [31:0] m_nonce [3];
    logic [31:0] m_x     [16];
    logic [31:0] exp_w   [16];
    logic [31:0] got     [16];
    logic [31:0] sav     [16];
    int          nwords, lat, seq_err, stab_err;
    logic        busy_at1;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    function automatic void tqr(input int a, input int b, input int c, input int d);
        m_x[a] = m_x[a] + m_x[b]; m_x[d] = rotl(m_x[d] ^ m_x[a], 16);
        m_x[c] = m_x[c] + m_x[d]; m_x[b] = rotl(m_x[b] ^ m_x[c], 12);
        m_x[a] = m_x[a] + m_x[b]; m_x[d] = rotl(m_x[d] ^ m_x[a], 8);
        m_x[c] = m_x[c] + m_x[d]; m_x[b] = rotl(m_x[b] ^ m_x[c], 7);
    endfunction

    function automatic void ref_block(input logic [31:0] ctr);
        logic [31:0] s [16];
        s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
        for (int i = 0; i < 8; i++) s[4 + i] = m_key[i];
        s[12] = ctr;
        for (int i = 0; i < 3; i++) s[13 + i] = m_nonce[i];
        for (int i = 0; i < 16; i++) m_x[i] = s[i];
        for (int r = 0; r < ROUNDS; r++) begin
            if (r % 2 == 0) begin
                for (int c = 0; c < 4; c++) tqr(c, c + 4, c + 8, c + 12);
            end else begin
                tqr(0, 5, 10, 15); tqr(1, 6, 11, 12); tqr(2, 7, 8, 13); tqr(3, 4, 9, 14);
            end
        end
        for (int i = 0; i < 16; i++) exp_w[i] = m_x[i] + s[i];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic set_rfc();
        for (int i = 0; i < 8; i++)
            m_key[i] = {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)};
        m_nonce[0] = 32'h09000000; m_nonce[1] = 32'h4a000000; m_nonce[2] = 32'h00000000;
    endtask

    task automatic set_rand();
        for (int i = 0; i < 8; i++) m_key[i] = $urandom;
        for (int i = 0; i < 3; i++) m_nonce[i] = $urandom;
    endtask

    task automatic load_all(input logic [31:0] ctr);
        for (int i = 0; i < 12; i++) begin
            Load = 1'b1; Load_addr = 4'(i);
            Load_data = (i < 8) ? m_key[i] : (i == 8) ? ctr : m_nonce[i - 9];
            step();
        end
        Load = 1'b1; Load_addr = 4'(12 + $urandom_range(0, 3)); Load_data = $urandom;
        step();
        Load = 1'b0;
    endtask

    // Start one block and collect it; inject=1 drives Start/Load while busy
    task automatic run_block(input bit bp, input bit inject);
        logic [31:0] p_d;
        logic [3:0]  p_i;
        logic        p_l;
        bit          stalled;
        int          cyc;
        Start = 1'b1; step(); Start = 1'b0; Load = 1'b0;
        lat = 1; busy_at1 = Busy;
        while (!Out_valid && lat < 100) begin
            if (inject && lat == 5) begin
                Start = 1'b1; Load = 1'b1; Load_addr = 4'd0; Load_data = 32'hDEADBEEF;
            end else begin
                Start = 1'b0; Load = 1'b0;
            end
            step(); lat++;
        end
        Start = 1'b0; Load = 1'b0;
        nwords = 0; seq_err = 0; stab_err = 0; stalled = 0; cyc = 0;
        p_d = '0; p_i = '0; p_l = 1'b0;
        while (Out_valid && nwords < 16 && cyc < 400) begin
            if (stalled && (Out_data !== p_d || Out_index !== p_i || Out_last !== p_l)) stab_err++;
            Out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (inject && nwords == 3) begin
                Start = 1'b1; Load = 1'b1; Load_addr = 4'd0; Load_data = 32'hDEADBEEF;
            end else begin
                Start = 1'b0; Load = 1'b0;
            end
            if (Out_ready) begin
                if (Out_index !== 4'(nwords)) seq_err++;
                if (Out_last !== 1'(nwords == 15)) seq_err++;
                got[nwords] = Out_data;
                nwords++;
                stalled = 0;
            end else begin
                stalled = 1; p_d = Out_data; p_i = Out_index; p_l = Out_last;
            end
            step(); cyc++;
        end
        Out_ready = 1'b0; Start = 1'b0; Load = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        Reset = 1'b0; Load = 0; Load_addr = 0; Load_data = 0; Start = 0; Out_ready = 0;
        step(); step();
        checks++; if (Busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", Busy); end
        checks++; if (Out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", Out_valid); end
        checks++; if (Out_data !== 32'd0) begin errors++; $display("FAIL reset_data got %h want 0", Out_data); end
        checks++; if (Out_index !== 4'd0) begin errors++; $display("FAIL reset_index got %0d want 0", Out_index); end
        checks++; if (Out_last !== 1'b0)  begin errors++; $display("FAIL reset_last got %b want 0", Out_last); end
        Reset = 1'b1; step();
    endtask

    task automatic test_rfc();
        set_rfc(); load_all(32'd1); ref_block(32'd1);
        run_block(1'b0, 1'b0);
        checks++; if (busy_at1 !== 1'b1) begin errors++; $display("FAIL rfc_busy_rise got %b want 1", busy_at1); end
        checks++; if (lat !== 23)   begin errors++; $display("FAIL rfc_latency got %0d want 23", lat); end
        checks++; if (nwords !== 16) begin errors++; $display("FAIL rfc_count got %0d want 16", nwords); end
        checks++; if (seq_err !== 0) begin errors++; $display("FAIL rfc_order got %0d errs want 0", seq_err); end
        checks++; if (got[0] !== 32'he4e7f110)  begin errors++; $display("FAIL rfc_w0 got %h want e4e7f110", got[0]); end
        checks++; if (got[1] !== 32'h15593bd1)  begin errors++; $display("FAIL rfc_w1 got %h want 15593bd1", got[1]); end
        checks++; if (got[15] !== 32'h4e3c50a2) begin errors++; $display("FAIL rfc_w15 got %h want 4e3c50a2", got[15]); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== exp_w[i]) begin errors++; $display("FAIL rfc_word[%0d] got %h want %h", i, got[i], exp_w[i]); end
        end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rfc_busy_fall got %b want 0", Busy); end
    endtask

    task automatic test_back_to_back();
        ref_block(32'd2);
        run_block(1'b0, 1'b0);
        checks++; if (nwords !== 16) begin errors++; $display("FAIL b2b_count got %0d want 16", nwords); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== exp_w[i]) begin errors++; $display("FAIL b2b_word[%0d] got %h want %h", i, got[i], exp_w[i]); end
        end
    endtask

    task automatic test_backpressure();
        set_rfc(); load_all(32'd1); ref_block(32'd1);
        run_block(1'b1, 1'b0);
        checks++; if (nwords !== 16)  begin errors++; $display("FAIL bp_count got %0d want 16", nwords); end
        checks++; if (seq_err !== 0)  begin errors++; $display("FAIL bp_order got %0d errs want 0", seq_err); end
        checks++; if (stab_err !== 0) begin errors++; $display("FAIL bp_stable got %0d errs want 0", stab_err); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== exp_w[i]) begin errors++; $display("FAIL bp_word[%0d] got %h want %h", i, got[i], exp_w[i]); end
        end
    endtask

    task automatic test_wrap();
        set_rand(); load_all(32'hFFFFFFFF); ref_block(32'hFFFFFFFF);
        run_block(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== exp_w[i]) begin errors++; $display("FAIL wrap_first[%0d] got %h want %h", i, got[i], exp_w[i]); end
        end
        ref_block(32'd0);
        run_block(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            sav[i] = got[i];
            checks++;
            if (got[i] !== exp_w[i]) begin errors++; $display("FAIL wrap_second[%0d] got %h want %h", i, got[i], exp_w[i]); end
        end
        // Counter reload to zero in the same cycle as Start
        Load = 1'b1; Load_addr = 4'd8; Load_data = 32'd0;
        run_block(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== sav[i]) begin errors++; $display("FAIL wrap_explicit0[%0d] got %h want %h", i, got[i], sav[i]); end
        end
    endtask

    task automatic test_ignored();
        set_rfc(); load_all(32'd1); ref_block(32'd1);
        run_block(1'b0, 1'b1);
        checks++; if (nwords !== 16) begin errors++; $display("FAIL ign_count got %0d want 16", nwords); end
        checks++; if (seq_err !== 0) begin errors++; $display("FAIL ign_order got %0d errs want 0", seq_err); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== exp_w[i]) begin errors++; $display("FAIL ign_block[%0d] got %h want %h", i, got[i], exp_w[i]); end
        end
        step(); step();
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL ign_no_restart got %b want 0", Busy); end
        ref_block(32'd2);
        run_block(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== exp_w[i]) begin errors++; $display("FAIL ign_next[%0d] got %h want %h", i, got[i], exp_w[i]); end
        end
    endtask

    task automatic test_reset_mid();
        int w;
        // Reset during ROUND
        set_rfc(); load_all(32'd1);
        Start = 1'b1; step(); Start = 1'b0;
        repeat (10) step();
        Reset = 1'b0; step();
        checks++; if (Busy !== 1'b0 || Out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_round_ctl got busy=%b valid=%b want 0 0", Busy, Out_valid); end
        checks++; if (Out_data !== 32'd0 || Out_index !== 4'd0 || Out_last !== 1'b0) begin
            errors++; $display("FAIL rst_round_out got %h/%0d/%b want 0/0/0", Out_data, Out_index, Out_last); end
        Reset = 1'b1; step();
        // Key, counter and nonce must be cleared by the reset
        for (int i = 0; i < 8; i++) m_key[i] = '0;
        for (int i = 0; i < 3; i++) m_nonce[i] = '0;
        ref_block(32'd0);
        run_block(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== exp_w[i]) begin errors++; $display("FAIL rst_cleared[%0d] got %h want %h", i, got[i], exp_w[i]); end
        end
        // Reset during OUT at index 7
        set_rfc(); load_all(32'd1);
        Start = 1'b1; step(); Start = 1'b0;
        w = 0;
        while (!Out_valid && w < 100) begin step(); w++; end
        Out_ready = 1'b1;
        repeat (7) step();
        Out_ready = 1'b0;
        checks++; if (Out_valid !== 1'b1 || Out_index !== 4'd7) begin
            errors++; $display("FAIL rst_out_reach got valid=%b idx=%0d want 1 7", Out_valid, Out_index); end
        Reset = 1'b0; step();
        checks++; if (Busy !== 1'b0 || Out_valid !== 1'b0) begin
            errors++; $display("FAIL rst_out_ctl got busy=%b valid=%b want 0 0", Busy, Out_valid); end
        checks++; if (Out_data !== 32'd0 || Out_index !== 4'd0 || Out_last !== 1'b0) begin
            errors++; $display("FAIL rst_out_out got %h/%0d/%b want 0/0/0", Out_data, Out_index, Out_last); end
        Reset = 1'b1; step();
        load_all(32'd1); ref_block(32'd1);
        run_block(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== exp_w[i]) begin errors++; $display("FAIL rst_reload[%0d] got %h want %h", i, got[i], exp_w[i]); end
        end
    endtask

`ifdef CHACHA_XOR_EN
    task automatic test_xor();
        set_rfc(); ref_block(32'd1);
        In_data = 32'h00000000; load_all(32'd1);
        run_block(1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== exp_w[i]) begin errors++; $display("FAIL xor0[%0d] got %h want %h", i, got[i], exp_w[i]); end
        end
        In_data = 32'hFFFFFFFF; load_all(32'd1);
        run_block(1'b0, 1'b0);
        checks++; if (got[0] !== 32'h1b180eef) begin errors++; $display("FAIL xor1_w0 got %h want 1b180eef", got[0]); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (got[i] !== ~exp_w[i]) begin errors++; $display("FAIL xor1[%0d] got %h want %h", i, got[i], ~exp_w[i]); end
        end
        In_data = 32'h00000000;
    endtask
`endif

    initial begin
`ifdef CHACHA_XOR_EN
        In_data = 32'h00000000;
`endif
        test_reset();
        test_rfc();
        test_back_to_back();
        test_backpressure();
        test_wrap();
        test_ignored();
        test_reset_mid();
`ifdef CHACHA_XOR_EN
        test_xor();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
